// File: rtl/burst_mem_bridge.sv
// Burst-to-single-word bridge: splits a cache burst into sequential word accesses; optional watchdog via BURST_TIMEOUT_EN.
// Latency: per word 1 cycle to backend strobe + backend latency + 1 cycle to the upstream ready pulse.
// Backpressure: one backend access outstanding; commands while busy are dropped, and the bridge stalls on mem_ready.
module burst_mem_bridge #(
  parameter int MAX_BURST = 32
`ifdef BURST_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        burst_en,
  input  logic [7:0]  burst_length,
  input  logic [31:0] lowmem_a,
  input  logic [31:0] lowmem_d,
  input  logic        lowmem_we,
  input  logic        lowmem_rd,
  output logic [31:0] lowmem_spo,
  output logic        lowmem_ready,
  output logic [31:0] mem_a,
  output logic [31:0] mem_d,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [31:0] mem_spo,
  input  logic        mem_ready,
  output logic        busy
`ifdef BURST_TIMEOUT_EN
  , output logic      err
`endif
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_LATCH, WR_REQ, WR_WAIT, DONE} state_t;

  localparam logic [7:0] MAX_LEN = 8'(MAX_BURST);

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [7:0]  len_q, len_d, cnt_q, cnt_d;
  logic [31:0] spo_q, spo_d;
  logic        ready_q, ready_d;
  logic [31:0] mem_a_q, mem_a_d, mem_d_q, mem_d_d;
  logic        mem_we_q, mem_we_d, mem_rd_q, mem_rd_d;

  logic [7:0]  req_len, cnt_inc;
  logic [31:0] word_addr, rd_word;
  logic        last_word, word_done, strobe_ok;

  always_comb begin
    req_len = 8'd1;
    if (burst_en) begin
      if (burst_length == 8'd0)        req_len = 8'd1;
      else if (burst_length > MAX_LEN) req_len = MAX_LEN;
      else                             req_len = burst_length;
    end
  end

  assign cnt_inc   = cnt_q + 8'd1;
  assign last_word = (cnt_inc >= len_q);
  assign word_addr = base_q + {22'd0, cnt_q, 2'b00};

`ifdef BURST_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;
  logic        abort_q, abort_d, err_q, err_d;
  logic        in_wait, wd_expired;

  assign in_wait    = (state_q == RD_WAIT) || (state_q == WR_WAIT);
  assign wd_expired = (wdog_q == 32'(TIMEOUT - 1));
  // Once a word times out, the rest of the burst completes locally without touching the backend.
  assign word_done  = mem_ready || abort_q || wd_expired;
  assign rd_word    = (mem_ready && !abort_q) ? mem_spo : 32'hDEAD_BEEF;
  assign strobe_ok  = !abort_q;

  always_comb begin
    wdog_d  = wdog_q;
    abort_d = abort_q;
    err_d   = err_q;
    if ((state_q == RD_REQ) || (state_q == WR_REQ)) wdog_d = 32'd0;
    else if (in_wait)                                wdog_d = wdog_q + 32'd1;
    if (in_wait && !mem_ready && !abort_q && wd_expired) begin
      abort_d = 1'b1;
      err_d   = 1'b1;
    end
    if (state_q == IDLE) abort_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q  <= 32'd0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  assign word_done = mem_ready;
  assign rd_word   = mem_spo;
  assign strobe_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    spo_d    = spo_q;
    ready_d  = 1'b0;
    mem_a_d  = mem_a_q;
    mem_d_d  = mem_d_q;
    mem_we_d = 1'b0;
    mem_rd_d = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (lowmem_we || lowmem_rd) begin
          base_d  = lowmem_a & ~32'h3;
          len_d   = req_len;
          cnt_d   = 8'd0;
          ready_d = 1'b0;
          state_d = lowmem_we ? WR_LATCH : RD_REQ;
        end
      end
      RD_REQ: begin
        mem_a_d  = word_addr;
        mem_rd_d = strobe_ok;
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        if (word_done) begin
          spo_d   = rd_word;
          ready_d = 1'b1;
          cnt_d   = cnt_inc;
          state_d = last_word ? DONE : RD_REQ;
        end
      end
      // Skip the pulse cycle so upstream has a full cycle to present the next word.
      WR_LATCH: begin
        if (!ready_q) begin
          mem_d_d = lowmem_d;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        mem_a_d  = word_addr;
        mem_we_d = strobe_ok;
        state_d  = WR_WAIT;
      end
      WR_WAIT: begin
        if (word_done) begin
          ready_d = 1'b1;
          cnt_d   = cnt_inc;
          state_d = last_word ? DONE : WR_LATCH;
        end
      end
      DONE: begin
        if (!ready_q) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      base_q   <= 32'd0;
      len_q    <= 8'd0;
      cnt_q    <= 8'd0;
      spo_q    <= 32'd0;
      ready_q  <= 1'b1;
      mem_a_q  <= 32'd0;
      mem_d_q  <= 32'd0;
      mem_we_q <= 1'b0;
      mem_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      spo_q    <= spo_d;
      ready_q  <= ready_d;
      mem_a_q  <= mem_a_d;
      mem_d_q  <= mem_d_d;
      mem_we_q <= mem_we_d;
      mem_rd_q <= mem_rd_d;
    end
  end

  assign lowmem_spo   = spo_q;
  assign lowmem_ready = ready_q;
  assign mem_a        = mem_a_q;
  assign mem_d        = mem_d_q;
  assign mem_we       = mem_we_q;
  assign mem_rd       = mem_rd_q;
  assign busy         = (state_q != IDLE);

endmodule
